// File: rtl/stereo_disparity_reader.sv
// Reads one line from the left/right strip RAMs and finds the disparity with the
// smallest windowed sum of absolute differences (ties go to the smaller disparity).
module stereo_disparity_reader #(
  parameter int LINE_LEN = 640,
  parameter int REF_COL  = 320,
  parameter int WIN      = 16,
  parameter int MAX_DISP = 64,
  parameter int RD_LAT   = 2,
  parameter int SAD_W    = 8
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        start,
  output logic [10:0]                 rdaddrl,
  output logic [10:0]                 rdaddrr,
  output logic                        rdclkl,
  output logic                        rdclkr,
  output logic                        rdenl,
  output logic                        rdenr,
  input  logic [2:0]                  datal,
  input  logic [2:0]                  datar,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(MAX_DISP)-1:0] disp,
  output logic [SAD_W-1:0]            sad,
  output logic [1:0]                  dbg_state
);
  localparam int AW    = 11;
  localparam int DW    = $clog2(MAX_DISP);
  localparam int IW    = $clog2(WIN);
  localparam int TAG_W = 3 + DW;

  if ((REF_COL < MAX_DISP - 1) || (REF_COL + WIN > LINE_LEN)) begin : g_bad_params
    $error("stereo_disparity_reader: window does not fit the stored line");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  // Handshake: start is a one-cycle request honoured only in IDLE (ignored otherwise);
  // busy is high in READ/DRAIN; done pulses one cycle and disp/sad hold until the next done.
  state_t            state_q, state_d;
  logic [IW-1:0]     i_q, i_d;
  logic [DW-1:0]     d_q, d_d;
  logic [AW-1:0]     addrl_q, addrl_d, addrr_q, addrr_d;
  logic              rden_q, rden_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;
  logic [DW-1:0]     best_disp_q, best_disp_d;
  logic [SAD_W-1:0]  sad_q, sad_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic [SAD_W-1:0]  acc_q, acc_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [SAD_W-1:0]  cmp_sad_q, cmp_sad_d;
  logic [DW-1:0]     cmp_disp_q, cmp_disp_d;
  logic [TAG_W-1:0]  tag_q [RD_LAT];
  logic [TAG_W-1:0]  tag_d [RD_LAT];

  logic [2:0]        absdiff;
  logic              tag_valid, tag_first, tag_last;
  logic [DW-1:0]     tag_disp;

  // Tag pipeline: entry 0 captures the pair currently on the address pins,
  // the last entry lines up with the RAM data for that pair.
  always_comb begin
    tag_d[0] = {rden_q, (i_q == '0), (i_q == IW'(WIN - 1)), d_q};
    for (int k = 1; k < RD_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    {tag_valid, tag_first, tag_last, tag_disp} = tag_q[RD_LAT-1];
    absdiff = (datal >= datar) ? (datal - datar) : (datar - datal);

    acc_d       = acc_q;
    cmp_valid_d = 1'b0;
    cmp_sad_d   = cmp_sad_q;
    cmp_disp_d  = cmp_disp_q;
    if (tag_valid) begin
      acc_d = tag_first ? SAD_W'(absdiff) : acc_q + SAD_W'(absdiff);
      if (tag_last) begin
        cmp_valid_d = 1'b1;
        cmp_sad_d   = acc_d;
        cmp_disp_d  = tag_disp;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    d_d         = d_q;
    addrl_d     = addrl_q;
    addrr_d     = addrr_q;
    rden_d      = 1'b0;
    best_sad_d  = best_sad_q;
    best_disp_d = best_disp_q;
    disp_d      = disp_q;
    sad_d       = sad_q;

    if (cmp_valid_q && (cmp_sad_q < best_sad_q)) begin
      best_sad_d  = cmp_sad_q;
      best_disp_d = cmp_disp_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_READ;
          i_d         = '0;
          d_d         = '0;
          addrl_d     = AW'(REF_COL);
          addrr_d     = AW'(REF_COL);
          rden_d      = 1'b1;
          best_sad_d  = '1;
          best_disp_d = '0;
        end
      end
      S_READ: begin
        if ((i_q == IW'(WIN - 1)) && (d_q == DW'(MAX_DISP - 1))) begin
          state_d = S_DRAIN;
        end else begin
          rden_d = 1'b1;
          if (i_q == IW'(WIN - 1)) begin
            i_d = '0;
            d_d = d_q + 1'b1;
          end else begin
            i_d = i_q + 1'b1;
          end
          addrl_d = AW'(REF_COL) + AW'(i_d);
          addrr_d = AW'(REF_COL) + AW'(i_d) - AW'(d_d);
        end
      end
      S_DRAIN: begin
        // The final compare is the one for the largest disparity.
        if (cmp_valid_q && (cmp_disp_q == DW'(MAX_DISP - 1))) begin
          state_d = S_DONE;
          disp_d  = best_disp_d;
          sad_d   = best_sad_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      d_q         <= '0;
      addrl_q     <= '0;
      addrr_q     <= '0;
      rden_q      <= 1'b0;
      best_sad_q  <= '1;
      best_disp_q <= '0;
      disp_q      <= '0;
      sad_q       <= '0;
      acc_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_sad_q   <= '0;
      cmp_disp_q  <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      d_q         <= d_d;
      addrl_q     <= addrl_d;
      addrr_q     <= addrr_d;
      rden_q      <= rden_d;
      best_sad_q  <= best_sad_d;
      best_disp_q <= best_disp_d;
      disp_q      <= disp_d;
      sad_q       <= sad_d;
      acc_q       <= acc_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_sad_q   <= cmp_sad_d;
      cmp_disp_q  <= cmp_disp_d;
      for (int k = 0; k < RD_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign rdaddrl   = addrl_q;
  assign rdaddrr   = addrr_q;
  assign rdenl     = rden_q;
  assign rdenr     = rden_q;
  assign rdclkl    = sysclk;
  assign rdclkr    = sysclk;
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign disp      = disp_q;
  assign sad       = sad_q;
  assign dbg_state = state_q;
endmodule
